// File: rtl/alu_pipe.sv
// Two-stage pipelined NZVC ALU with valid/ready on both sides and a carry-chaining flag register.
// Define ALU_PIPE_SAT_EN to make ADD/INC/SUB/DEC/ADC/SBC saturate on signed overflow.
module alu_pipe #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       ALU_Sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Result,
  output logic [3:0]       NZVC
);

  typedef enum logic [3:0] {
    OpAdd, OpInc, OpSub, OpDec, OpAnd, OpOr, OpXor, OpNot,
    OpAdc, OpSbc, OpShl, OpShr, OpAsr, OpCmp, OpPassb, OpClrf
  } op_e;

  localparam int unsigned Msb = WIDTH - 1;
  localparam logic [WIDTH-1:0] One = WIDTH'(1);
`ifdef ALU_PIPE_SAT_EN
  localparam logic [WIDTH-1:0] SatMax = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SatMin = {1'b1, {(WIDTH-1){1'b0}}};
`endif

  logic             s1_valid;
  logic [WIDTH-1:0] s1_a, s1_b;
  op_e              s1_op;
  logic [3:0]       flags_q;
  logic             adv2;

  logic [WIDTH-1:0] arith_b;
  logic             arith_ci;
  logic [WIDTH:0]   sum, diff;
  logic             v_add, v_sub;
  logic [WIDTH-1:0] res_d, flag_val;
  logic             v, c, clr, use_diff;
  logic [3:0]       nzvc_d;

  assign adv2     = !out_valid || out_ready;
  assign in_ready = !s1_valid || adv2;
  assign NZVC     = flags_q;

  // Shared adder/subtractor operands: INC/DEC use a constant one, ADC/SBC chain the stored carry.
  always_comb begin
    arith_b  = s1_b;
    arith_ci = 1'b0;
    case (s1_op)
      OpInc, OpDec: arith_b  = One;
      OpAdc, OpSbc: arith_ci = flags_q[0];
      default: ;
    endcase
  end

  assign sum   = {1'b0, s1_a} + {1'b0, arith_b} + {{WIDTH{1'b0}}, arith_ci};
  assign diff  = {1'b0, s1_a} - {1'b0, arith_b} - {{WIDTH{1'b0}}, arith_ci};
  assign v_add = (s1_a[Msb] == arith_b[Msb]) && (sum[Msb] != s1_a[Msb]);
  assign v_sub = (s1_a[Msb] != arith_b[Msb]) && (diff[Msb] != s1_a[Msb]);

  always_comb begin
    res_d    = '0;
    v        = 1'b0;
    c        = 1'b0;
    clr      = 1'b0;
    use_diff = 1'b0;
    case (s1_op)
      OpAdd, OpInc, OpAdc: begin
        res_d = sum[Msb:0];
        v     = v_add;
        c     = sum[WIDTH];
      end
      OpSub, OpDec, OpSbc: begin
        res_d = diff[Msb:0];
        v     = v_sub;
        c     = diff[WIDTH];
      end
      OpAnd:   res_d = s1_a & s1_b;
      OpOr:    res_d = s1_a | s1_b;
      OpXor:   res_d = s1_a ^ s1_b;
      OpNot:   res_d = ~s1_a;
      OpShl: begin
        res_d = {s1_a[Msb-1:0], 1'b0};
        c     = s1_a[Msb];
      end
      OpShr: begin
        res_d = {1'b0, s1_a[Msb:1]};
        c     = s1_a[0];
      end
      OpAsr: begin
        res_d = {s1_a[Msb], s1_a[Msb:1]};
        c     = s1_a[0];
      end
      OpCmp: begin
        res_d    = s1_a;
        v        = v_sub;
        c        = diff[WIDTH];
        use_diff = 1'b1;
      end
      OpPassb: res_d = s1_b;
      OpClrf:  clr   = 1'b1;
      default: ;
    endcase
`ifdef ALU_PIPE_SAT_EN
    // Overflow direction follows the sign of A for both add- and subtract-type ops.
    if (v && s1_op != OpCmp) res_d = s1_a[Msb] ? SatMin : SatMax;
`endif
    flag_val = use_diff ? diff[Msb:0] : res_d;
    nzvc_d   = clr ? 4'b0000 : {flag_val[Msb], flag_val == '0, v, c};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_a      <= '0;
      s1_b      <= '0;
      s1_op     <= OpAdd;
      out_valid <= 1'b0;
      Result    <= '0;
      flags_q   <= 4'b0000;
    end else begin
      if (in_ready) begin
        s1_valid <= in_valid;
        if (in_valid) begin
          s1_a  <= A;
          s1_b  <= B;
          s1_op <= op_e'(ALU_Sel);
        end
      end
      if (adv2) begin
        out_valid <= s1_valid;
        if (s1_valid) begin
          Result  <= res_d;
          flags_q <= nzvc_d;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe: directed vector table, handshake corner cases and a
// randomized stream scored against an arithmetic reference model.
module tb_alu_pipe;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst, in_valid, in_ready, out_valid, out_ready;
  logic [W-1:0] a, b, result;
  logic [3:0]   sel, nzvc;

  alu_pipe #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .A(a), .B(b),
    .ALU_Sel(sel), .out_valid(out_valid), .out_ready(out_ready), .Result(result), .NZVC(nzvc)
  );

  always #5 clk = ~clk;

  typedef struct { logic [3:0] sel; logic [W-1:0] a; logic [W-1:0] b; } op_t;
  typedef struct {
    logic [3:0] sel; logic [W-1:0] a; logic [W-1:0] b; logic [W-1:0] res; logic [3:0] nzvc;
  } vec_t;

  int           n_vec = 0, n_bad = 0, out_cnt = 0;
  vec_t         vecs[$];
  op_t          sb_q[$];
  op_t          mo;
  logic [W+3:0] mexp;
  bit           sb_en = 0, done = 0;
  logic         m_cf = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_timeout(input string name);
    n_vec++;
    n_bad++;
    $display("FAIL %s: timed out", name);
  endtask

  // Reference: plain integer arithmetic on unsigned and signed views of the operands.
  function automatic logic [W+3:0] model(input logic [3:0] op, input logic [W-1:0] x,
                                         input logic [W-1:0] y, input logic cf);
    longint ux = longint'(x), uy = longint'(y), ci = longint'(cf);
    longint sx = longint'($signed(x)), sy = longint'($signed(y));
    longint umax = (longint'(1) << W) - 1;
    longint smax = (longint'(1) << (W - 1)) - 1;
    longint smin = -smax - 1;
    longint ut = 0, st = 0;
    logic [W-1:0] r = '0, fv;
    logic v = 1'b0, c = 1'b0;
    bit arith = 0, cmp = 0, clr = 0;
    case (op)
      4'd0:  begin ut = ux + uy;      st = sx + sy;      c = ut > umax;     arith = 1; end
      4'd1:  begin ut = ux + 1;       st = sx + 1;       c = ut > umax;     arith = 1; end
      4'd2:  begin ut = ux - uy;      st = sx - sy;      c = ux < uy;       arith = 1; end
      4'd3:  begin ut = ux - 1;       st = sx - 1;       c = ux < 1;        arith = 1; end
      4'd4:  r = x & y;
      4'd5:  r = x | y;
      4'd6:  r = x ^ y;
      4'd7:  r = ~x;
      4'd8:  begin ut = ux + uy + ci; st = sx + sy + ci; c = ut > umax;     arith = 1; end
      4'd9:  begin ut = ux - uy - ci; st = sx - sy - ci; c = ux < uy + ci;  arith = 1; end
      4'd10: begin r = x << 1; c = x[W-1]; end
      4'd11: begin r = x >> 1; c = x[0]; end
      4'd12: begin r = W'($signed(x) >>> 1); c = x[0]; end
      4'd13: begin ut = ux - uy; st = sx - sy; c = ux < uy; arith = 1; cmp = 1; end
      4'd14: r = y;
      default: clr = 1;
    endcase
    if (arith) begin
      r = ut[W-1:0];
      v = (st > smax) || (st < smin);
    end
`ifdef ALU_PIPE_SAT_EN
    if (v && !cmp) r = (st > 0) ? smax[W-1:0] : smin[W-1:0];
`endif
    fv = r;
    if (cmp) r = x;
    if (clr) return '0;
    return {r, fv[W-1], fv == '0, v, c};
  endfunction

  // Scoreboard: in-order queue of accepted bundles, flags chained through the model.
  always @(negedge clk) begin
    if (sb_en) begin
      if (rst) begin
        sb_q.delete();
        m_cf = 1'b0;
      end else begin
        if (out_valid && out_ready) begin
          if (sb_q.size() == 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL sb_spurious_output: got 0x%0h, want nothing", result);
          end else begin
            mo   = sb_q.pop_front();
            mexp = model(mo.sel, mo.a, mo.b, m_cf);
            check($sformatf("sb_result op%0d a=%0h b=%0h", mo.sel, mo.a, mo.b), result,
                  mexp[W+3:4]);
            check($sformatf("sb_nzvc op%0d a=%0h b=%0h", mo.sel, mo.a, mo.b), nzvc, mexp[3:0]);
            m_cf = mexp[0];
          end
          out_cnt++;
        end
        if (in_valid && in_ready) sb_q.push_back('{sel: sel, a: a, b: b});
      end
    end
  end

  task automatic do_reset();
    rst      = 1'b1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    sb_q.delete();
    m_cf = 1'b0;
  endtask

  // Presents a bundle and holds it until the edge that accepts it; leaves in_valid high.
  task automatic send(input logic [3:0] s, input logic [W-1:0] x, input logic [W-1:0] y);
    logic acc;
    sel = s; a = x; b = y; in_valid = 1'b1;
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk); #1;
      if (acc) return;
    end
    fail_timeout("send_accept");
  endtask

  task automatic wait_out(input string name);
    @(negedge clk);
    for (int t = 0; t < 20 && !out_valid; t++) @(negedge clk);
    if (!out_valid) fail_timeout(name);
  endtask

  task automatic add_vec(input logic [3:0] s, input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic [W-1:0] r, input logic [3:0] f);
    vecs.push_back('{sel: s, a: x, b: y, res: r, nzvc: f});
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [W-1:0] held;
    int rem;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; sel = '0;
    @(posedge clk); #1;
    rst = 1'b0;
    check("reset_out_valid", out_valid, 0);
    check("reset_result", result, 0);
    check("reset_nzvc", nzvc, 0);
    check("reset_in_ready", in_ready, 1);

    // Latency: presented after edge k, S1 at k+1, output valid at k+2.
    a = 8'd1; b = 8'd5; sel = 4'd0; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("latency_not_yet_valid", out_valid, 0);
    @(posedge clk); #1;
    check("latency_out_valid", out_valid, 1);
    check("latency_result", result, 8'h06);
    check("latency_nzvc", nzvc, 4'b0000);
    @(posedge clk); #1;

    // Directed table; order matters because ADC/SBC chain the previous carry.
    add_vec(4'd0,  8'h01, 8'h05, 8'h06, 4'b0000);
`ifdef ALU_PIPE_SAT_EN
    add_vec(4'd1,  8'h7F, 8'h00, 8'h7F, 4'b0010);
`else
    add_vec(4'd1,  8'h7F, 8'h00, 8'h80, 4'b1010);
`endif
    add_vec(4'd0,  8'hFF, 8'h01, 8'h00, 4'b0101);
    add_vec(4'd8,  8'h00, 8'h00, 8'h01, 4'b0000);
    add_vec(4'd2,  8'd17, 8'd40, 8'hE9, 4'b1001);
    add_vec(4'd13, 8'd73, 8'd73, 8'd73, 4'b0100);
    add_vec(4'd2,  8'h00, 8'h01, 8'hFF, 4'b1001);
    add_vec(4'd9,  8'h10, 8'h05, 8'h0A, 4'b0000);
`ifdef ALU_PIPE_SAT_EN
    add_vec(4'd3,  8'h80, 8'h00, 8'h80, 4'b1010);
`else
    add_vec(4'd3,  8'h80, 8'h00, 8'h7F, 4'b0010);
`endif
    add_vec(4'd4,  8'hF0, 8'h3C, 8'h30, 4'b0000);
    add_vec(4'd5,  8'hF0, 8'h0C, 8'hFC, 4'b1000);
    add_vec(4'd6,  8'hAA, 8'hAA, 8'h00, 4'b0100);
    add_vec(4'd7,  8'h0F, 8'h00, 8'hF0, 4'b1000);
    add_vec(4'd10, 8'h81, 8'h00, 8'h02, 4'b0001);
    add_vec(4'd11, 8'h81, 8'h00, 8'h40, 4'b0001);
    add_vec(4'd12, 8'h81, 8'h00, 8'hC0, 4'b1001);
`ifdef ALU_PIPE_SAT_EN
    add_vec(4'd8,  8'h7F, 8'h00, 8'h7F, 4'b0010);
`else
    add_vec(4'd8,  8'h7F, 8'h00, 8'h80, 4'b1010);
`endif
    add_vec(4'd14, 8'h12, 8'h9C, 8'h9C, 4'b1000);
    add_vec(4'd10, 8'h80, 8'h00, 8'h00, 4'b0101);
    add_vec(4'd15, 8'h55, 8'h66, 8'h00, 4'b0000);
    add_vec(4'd8,  8'h00, 8'h00, 8'h00, 4'b0100);
    add_vec(4'd13, 8'h10, 8'h20, 8'h10, 4'b1001);
`ifdef ALU_PIPE_SAT_EN
    add_vec(4'd0,  8'h80, 8'h80, 8'h80, 4'b1011);
`else
    add_vec(4'd0,  8'h80, 8'h80, 8'h00, 4'b0111);
`endif

    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < vecs.size(); i++) begin
      send(vecs[i].sel, vecs[i].a, vecs[i].b);
      in_valid = 1'b0;
      wait_out($sformatf("vec%0d_wait", i));
      check($sformatf("vec%0d_result", i), result, vecs[i].res);
      check($sformatf("vec%0d_nzvc", i), nzvc, vecs[i].nzvc);
      @(posedge clk); #1;
    end

    // Reset with two ops in flight discards them and clears the stored carry.
    do_reset();
    out_ready = 1'b0;
    send(4'd0, 8'hFF, 8'h01);
    send(4'd2, 8'h03, 8'h01);
    in_valid = 1'b0;
    check("pre_reset_out_valid", out_valid, 1);
    check("pre_reset_nzvc", nzvc, 4'b0101);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midreset_out_valid", out_valid, 0);
    check("midreset_nzvc", nzvc, 4'b0000);
    check("midreset_in_ready", in_ready, 1);
    out_ready = 1'b1;
    send(4'd8, 8'h00, 8'h00);
    in_valid = 1'b0;
    wait_out("post_reset_adc_wait");
    check("post_reset_adc_result", result, 8'h00);
    check("post_reset_adc_nzvc", nzvc, 4'b0100);
    @(posedge clk); #1;

    // Six back-to-back ops with a four-cycle output stall mid-stream.
    do_reset();
    out_cnt = 0;
    out_ready = 1'b1;
    sb_en = 1;
    fork
      begin
        for (int i = 0; i < 6; i++)
          send(4'($urandom_range(0, 15)), W'($urandom), W'($urandom));
        in_valid = 1'b0;
      end
      begin
        repeat (3) @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        held = result;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("stall_in_ready_low", in_ready, 0);
        check("stall_out_valid_held", out_valid, 1);
        check("stall_result_stable", result, held);
        @(posedge clk); #1;
        out_ready = 1'b1;
        rem = 6 - out_cnt;
        for (int i = 0; i < rem; i++) begin
          @(negedge clk);
          check($sformatf("stream_throughput_%0d", i), out_valid, 1);
        end
      end
    join
    for (int t = 0; t < 20 && sb_q.size() != 0; t++) @(posedge clk);
    #1;
    check("stream_out_count", out_cnt, 6);
    check("stream_queue_empty", sb_q.size(), 0);

    // Randomized traffic with random backpressure.
    do_reset();
    done = 0;
    fork
      begin
        for (int i = 0; i < 250; i++) begin
          repeat ($urandom_range(0, 2)) begin
            in_valid = 1'b0;
            @(posedge clk); #1;
          end
          send(4'($urandom_range(0, 15)), W'($urandom), W'($urandom));
        end
        in_valid = 1'b0;
        done = 1;
      end
      begin
        while (!done) begin
          out_ready = ($urandom_range(0, 99) < 70);
          @(posedge clk); #1;
        end
        out_ready = 1'b1;
      end
    join
    for (int t = 0; t < 20 && sb_q.size() != 0; t++) @(posedge clk);
    #1;
    check("random_queue_drained", sb_q.size(), 0);
    sb_en = 0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
